usd_spi_host: RTL

//  Second-generation SD/SPI host for the Enterprise I/O space; Z80 talks to it through 5 registers.

---
 rtl/usd_spi_host_if.sv | 24 ++
 rtl/usd_spi_host.sv | 253 +++++++++++++++++++++++++
 2 files changed

// File: rtl/usd_spi_host_if.sv
// usd_spi_host_if
//   CPU-side I/O bus between the Z80 decode and the SD/SPI host.
//   master : CPU side, drives the strobes, address and write data
//   slave  : host side, returns registered read data on q
// Signals
//   cecpu  CPU clock enable; the bus is only meaningful while high
//   ioSD   I/O decode select for the host
//   rd     read strobe, active low
//   wr     write strobe, active low
//   a      CPU address, a[2:0] selects the register
//   d      write data
//   q      read data
interface usd_spi_host_if;
  logic       cecpu;
  logic       ioSD;
  logic       rd;
  logic       wr;
  logic [7:0] a;
  logic [7:0] d;
  logic [7:0] q;

  modport master (output cecpu, ioSD, rd, wr, a, d, input q);
  modport slave  (input cecpu, ioSD, rd, wr, a, d, output q);
endinterface

// File: rtl/usd_spi_host.sv
// usd_spi_host
//   SD card / SPI flash host for the Enterprise I/O space. The Z80 sees five
//   registers: DATA(0), CS(1), PAGE(2), CTRL(3), STATUS(4); 5-7 read FF.
//   Contains the chip-select register, ROM page bits, runtime SPI clock
//   divider and a mode-0, MSB-first byte shifter.
// Optional feature
//   USD_SPI_IRQ_EN : when defined, irq is a flop set on transfer completion and
//                    cleared by a DATA or STATUS read. Undefined: irq tied low.
// Ports
//   clock  system clock
//   reset  asynchronous reset, active low
//   bus    CPU bus (usd_spi_host_if.slave)
//   page   ROM page bits
//   cs     chip selects, active low (cs = ~sel)
//   ck     SPI clock, idle low
//   mosi   SPI data out, idles high
//   miso   SPI data in
//   busy   transfer in progress
//   irq    transfer-complete interrupt
// Parameters
//   CS_COUNT 1..6, DIV_BITS 1..6 (both must leave room in the 8-bit read words)
//
// state   | meaning
// --------+--------------------------------------------------------------
// S_IDLE  | no transfer; ck low, mosi high
// S_START | one clock after the strobe; mosi already holds bit 7,
//         | half-period counter is loaded from the current divider
// S_XFER  | 16 half-periods, each div+1 clocks; odd ones raise ck and
//         | sample miso, even ones drop ck and present the next bit
module usd_spi_host #(
  parameter int CS_COUNT    = 2,
  parameter int DIV_BITS    = 4,
  parameter int DIV_DEFAULT = 3
) (
  input  logic                clock,
  input  logic                reset,
  usd_spi_host_if.slave       bus,
  output logic [2:0]          page,
  output logic [CS_COUNT-1:0] cs,
  output logic                ck,
  output logic                mosi,
  input  logic                miso,
  output logic                busy,
  output logic                irq
);

  localparam logic [2:0] R_DATA   = 3'd0;
  localparam logic [2:0] R_CS     = 3'd1;
  localparam logic [2:0] R_PAGE   = 3'd2;
  localparam logic [2:0] R_CTRL   = 3'd3;
  localparam logic [2:0] R_STATUS = 3'd4;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_START = 2'd1,
    S_XFER  = 2'd2
  } state_t;

  state_t state, state_n;

  logic [CS_COUNT-1:0] sel;
  logic                hs;
  logic [DIV_BITS-1:0] div;
  logic                ovr;
  logic [7:0]          rx;
  logic [7:0]          rx_sh;
  logic [7:0]          tx_sh;
  logic [DIV_BITS-1:0] cnt;
  logic [3:0]          hp;

  // Access strobes: one pulse on the first enabled cycle of an access. The
  // "seen" flags only advance on cecpu cycles so a held access never repeats.
  logic rd_act, wr_act, rd_seen, wr_seen, rd_stb, wr_stb;
  logic [2:0] reg_sel;
  logic unused_addr;

  assign rd_act      = bus.ioSD && !bus.rd;
  assign wr_act      = bus.ioSD && !bus.wr;
  assign rd_stb      = bus.cecpu && rd_act && !rd_seen;
  assign wr_stb      = bus.cecpu && wr_act && !wr_seen;
  assign reg_sel     = bus.a[2:0];
  assign unused_addr = ^bus.a[7:3];

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      rd_seen <= 1'b0;
      wr_seen <= 1'b0;
    end else if (bus.cecpu) begin
      rd_seen <= rd_act;
      wr_seen <= wr_act;
    end
  end

  // Transfer requests. A DATA write with hs=1, or a DATA read with hs=1,
  // sends FF so software can clock in card responses.
  logic       any_sel;
  logic       data_wr, data_rd;
  logic       start_req;
  logic [7:0] start_byte;

  assign any_sel    = |sel;
  assign data_wr    = wr_stb && (reg_sel == R_DATA);
  assign data_rd    = rd_stb && (reg_sel == R_DATA);
  assign start_req  = (data_wr || (data_rd && hs)) && !busy && any_sel;
  assign start_byte = (data_wr && !hs) ? bus.d : 8'hFF;

  // FSM: state register
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) state <= S_IDLE;
    else        state <= state_n;
  end

  // FSM: next state
  logic tc;
  assign tc = (cnt == '0);

  always_comb begin
    state_n = state;
    case (state)
      S_IDLE:  if (start_req) state_n = S_START;
      S_START: state_n = S_XFER;
      S_XFER:  if (tc && (hp == 4'd15)) state_n = S_IDLE;
      default: state_n = S_IDLE;
    endcase
  end

  // FSM: outputs / datapath controls
  logic load, hp_end, ck_rise, done;

  always_comb begin
    busy    = 1'b0;
    load    = 1'b0;
    hp_end  = 1'b0;
    ck_rise = 1'b0;
    done    = 1'b0;
    case (state)
      S_START: begin
        busy = 1'b1;
        load = 1'b1;
      end
      S_XFER: begin
        busy    = 1'b1;
        hp_end  = tc;
        ck_rise = tc && !hp[0];
        done    = tc && (hp == 4'd15);
      end
      default: ;
    endcase
  end

  // Shifter datapath. The divider is reloaded at every half-period boundary,
  // so a CTRL write mid-transfer only changes the following half-period and
  // ck never toggles after less than one clock.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      cnt   <= '0;
      hp    <= '0;
      ck    <= 1'b0;
      mosi  <= 1'b1;
      tx_sh <= 8'hFF;
      rx_sh <= 8'hFF;
      rx    <= 8'hFF;
    end else begin
      if (start_req) begin
        mosi  <= start_byte[7];
        tx_sh <= {start_byte[6:0], 1'b1};
      end
      if (load) begin
        cnt <= div;
        hp  <= '0;
      end else if (hp_end) begin
        cnt <= div;
        hp  <= hp + 4'd1;
        if (ck_rise) begin
          ck    <= 1'b1;
          rx_sh <= {rx_sh[6:0], miso};
        end else begin
          ck <= 1'b0;
          if (done) begin
            rx   <= rx_sh;
            mosi <= 1'b1;
          end else begin
            mosi  <= tx_sh[7];
            tx_sh <= {tx_sh[6:0], 1'b1};
          end
        end
      end else if (state == S_XFER) begin
        cnt <= cnt - DIV_BITS'(1);
      end
    end
  end

  // Register file
  logic ovr_set, ovr_clr;
  assign ovr_set = data_wr && busy;
  assign ovr_clr = rd_stb && (reg_sel == R_STATUS);

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      sel  <= '0;
      page <= 3'd0;
      hs   <= 1'b0;
      div  <= DIV_BITS'(DIV_DEFAULT);
      ovr  <= 1'b0;
    end else begin
      ovr <= (ovr && !ovr_clr) || ovr_set;
      if (wr_stb) begin
        case (reg_sel)
          R_CS:   sel  <= bus.d[CS_COUNT-1:0];
          R_PAGE: page <= bus.d[7:5];
          R_CTRL: begin
            hs  <= bus.d[7];
            div <= bus.d[DIV_BITS-1:0];
          end
          default: ;
        endcase
      end
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      bus.q <= 8'hFF;
    end else if (rd_stb) begin
      case (reg_sel)
        R_DATA:   bus.q <= rx;
        R_CS:     bus.q <= {{(8-CS_COUNT){1'b0}}, sel};
        R_PAGE:   bus.q <= {page, 5'b0};
        R_CTRL:   bus.q <= {hs, {(7-DIV_BITS){1'b0}}, div};
        R_STATUS: bus.q <= {busy, hs, ovr, 4'b0, any_sel};
        default:  bus.q <= 8'hFF;
      endcase
    end
  end

  assign cs = ~sel;

`ifdef USD_SPI_IRQ_EN
  logic irq_r, irq_clr;
  assign irq_clr = rd_stb && ((reg_sel == R_DATA) || (reg_sel == R_STATUS));

  always_ff @(posedge clock or negedge reset) begin
    if (!reset)       irq_r <= 1'b0;
    else if (done)    irq_r <= 1'b1;
    else if (irq_clr) irq_r <= 1'b0;
  end

  assign irq = irq_r;
`else
  assign irq = 1'b0;
`endif

endmodule
